// File: rtl/genrand_pkg.sv
// Shared definitions for the random-range path: default sizes, controller
// states and the range-mask helper.
package genrand_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Smallest all-ones mask covering n-1; n == 0 stands for the full 2^WIDTH range.
  function automatic logic [WIDTH_DEF-1:0] mask_for(input logic [WIDTH_DEF-1:0] n);
    logic [WIDTH_DEF-1:0] m;
    if (n == '0) begin
      m = '1;
    end else begin
      m = n - 1'b1;
      // Smear the highest set bit downwards so every lower bit is set.
      for (int s = 1; s < WIDTH_DEF; s = s * 2) begin
        m = m | (m >> s);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/rand_fifo.sv
// Small synchronous FIFO holding accepted samples. Occupancy is tracked in an
// explicit counter so full/empty never depend on pointer comparison; a flush
// empties it in one edge and takes priority over push and pop.
module rand_fifo
  import genrand_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees the slot in the same edge, so a full FIFO still takes a push
  // when it is popped simultaneously (the head slot is overwritten).
  assign do_pop  = pop_i & ~empty & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full | do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/randrange.sv
// Turns the free-running xorshift stream into uniform values in [0, N-1]
// by masked rejection sampling, buffering accepted values in rand_fifo.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_INIT  | first cycle after reset: capture range_n, no sampling
//   ST_RUN   | sample every valid word; mismatch on range_n flushes
//   ST_FLUSH | FIFO already emptied, new range captured; ignore all traffic
module randrange
  import genrand_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rnd_in,
  input  logic             rnd_valid,
  input  logic [WIDTH-1:0] range_n,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic [15:0]      reject_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic [15:0]      rej_q, rej_d;
  logic [WIDTH-1:0] mask, cand;
  logic             accept;
  logic             fifo_push, fifo_pop, fifo_flush;

  // Mask comes from the registered range only, keeping range_n off the
  // accept path except for the mismatch compare.
  assign mask   = mask_for(range_q);
  assign cand   = rnd_in & mask;
  assign accept = (range_q == '0) || (cand < range_q);

  // out_valid depends only on registered state, never on rnd_in.
  assign out_valid = (count != '0) && (state_q != ST_FLUSH);

  // Controller next state, FIFO strobes and reject counter update.
  always_comb begin
    state_d    = state_q;
    range_d    = range_q;
    rej_d      = rej_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_INIT: begin
        range_d = range_n;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        fifo_pop = out_valid & out_ready;
        if (range_n != range_q) begin
          // Empty now so the FLUSH cycle already shows an empty FIFO; the
          // sample arriving with the new range is not evaluated.
          fifo_flush = 1'b1;
          range_d    = range_n;
          state_d    = ST_FLUSH;
        end else if (rnd_valid) begin
          if (accept) begin
            fifo_push = 1'b1;
          end else if (rej_q != 16'hFFFF) begin
            rej_d = rej_q + 16'd1;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Controller state, captured range and reject counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      range_q <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      range_q <= range_d;
      rej_q   <= rej_d;
    end
  end

  rand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_i  (cand),
    .data_o  (out_data),
    .count_o (count)
  );

  assign reject_cnt = rej_q;

endmodule

// File: tb/tb_randrange.sv
module tb_randrange;
  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] rnd_in = '0;
  logic         rnd_valid = 1'b0;
  logic [W-1:0] range_n = '0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic [2:0]   count;
  logic [15:0]  reject_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Scoreboard: expected FIFO contents in order, and values actually delivered.
  int exp_q[$];
  int got[$];

  // Reference-model state.
  bit m_init = 1'b1;
  bit m_flush = 1'b0;
  int m_range = 0;
  int m_rej = 0;

  randrange #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .rnd_in     (rnd_in),
    .rnd_valid  (rnd_valid),
    .range_n    (range_n),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs applied here take effect at the next rising edge.
  task automatic cyc(input bit v, input int r, input int n, input bit rdy);
    @(negedge clk);
    #1;
    rnd_valid = v;
    rnd_in    = W'(r);
    range_n   = W'(n);
    out_ready = rdy;
  endtask

  task automatic idle(input int k, input int n, input bit rdy);
    repeat (k) cyc(1'b0, 0, n, rdy);
  endtask

  // Behavioural reference: applies the sampling rules to the queue at each edge.
  always @(posedge clk or negedge rst) begin : model
    int n, m, c;
    if (!rst) begin
      exp_q.delete();
      m_init  = 1'b1;
      m_flush = 1'b0;
      m_range = 0;
      m_rej   = 0;
    end else if (m_init) begin
      m_range = int'(range_n);
      m_init  = 1'b0;
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (int'(range_n) != m_range) begin
      exp_q.delete();
      m_range = int'(range_n);
      m_flush = 1'b1;
    end else if (rnd_valid) begin
      n = (m_range == 0) ? 65536 : m_range;
      m = 0;
      while (m < n - 1) m = m * 2 + 1;
      c = int'(rnd_in) & m;
      if (c < n) begin
        if (exp_q.size() < D) exp_q.push_back(c);
      end else if (m_rej < 65535) begin
        m_rej++;
      end
    end
  end

  // Monitor: compares registered outputs mid-cycle, records handshakes.
  always begin
    @(negedge clk);
    #3;
    chk("out_valid", int'(out_valid), int'(exp_q.size() != 0 && !m_flush));
    chk("count", int'(count), exp_q.size());
    chk("reject_cnt", int'(reject_cnt), m_rej);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_data: value 0x%0h presented, none expected at %0t", out_data, $time);
      end else begin
        chk("out_data", int'(out_data), exp_q[0]);
        if (out_ready) begin
          got.push_back(int'(out_data));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : main
    int acc;
    int cur_n;
    int rtab[9];
    rtab = '{0, 1, 2, 3, 6, 10, 16'h8000, 16'h8001, 16'hFFFF};

    // Reset held with the generator stream toggling.
    #2 rst = 1'b0;
    repeat (3) begin
      cyc(1'b1, $urandom, 10, 1'b1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_reject", int'(reject_cnt), 0);
      chk("rst_out_data", int'(out_data), 0);
    end
    cyc(1'b1, 16'h0003, 10, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 16'h0003, 10, 1'b0);
    chk("init_no_push", int'(count), 0);
    cyc(1'b0, 0, 10, 1'b1);
    chk("first_push", int'(count), 1);
    idle(1, 10, 1'b1);
    got.delete();

    // Accept/reject with N=10.
    cyc(1'b1, 16'h1237, 10, 1'b1);
    cyc(1'b1, 16'h004C, 10, 1'b1);
    cyc(1'b1, 16'hFFF9, 10, 1'b1);
    idle(2, 10, 1'b1);
    chk("ar_num_out", got.size(), 2);
    if (got.size() == 2) begin
      chk("ar_out0", got[0], 7);
      chk("ar_out1", got[1], 9);
    end
    chk("ar_reject", int'(reject_cnt), 1);

    // Full and drop with pass-through range.
    idle(2, 0, 1'b0);
    got.delete();
    for (int i = 1; i <= 5; i++) cyc(1'b1, i, 0, 1'b0);
    idle(1, 0, 1'b0);
    chk("full_count", int'(count), 4);
    idle(5, 0, 1'b1);
    chk("drain_num", got.size(), 4);
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("drain_order", got[i], i + 1);
    end
    chk("full_reject", int'(reject_cnt), 1);

    // Full with simultaneous pop and push.
    got.delete();
    for (int i = 1; i <= 4; i++) cyc(1'b1, i, 0, 1'b0);
    cyc(1'b1, 16'h00AA, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0);
    chk("pp_count", int'(count), 4);
    idle(5, 0, 1'b1);
    chk("pp_num", got.size(), 5);
    if (got.size() == 5) chk("pp_last", got[4], 16'h00AA);

    // Range change 10 -> 6 with three entries queued.
    idle(2, 10, 1'b0);
    got.delete();
    for (int i = 1; i <= 3; i++) cyc(1'b1, i, 10, 1'b0);
    cyc(1'b0, 0, 6, 1'b0);
    chk("rc_queued", int'(count), 3);
    cyc(1'b1, 2, 6, 1'b1);
    chk("rc_flush_valid", int'(out_valid), 0);
    chk("rc_flush_count", int'(count), 0);
    cyc(1'b1, 6, 6, 1'b1);
    chk("rc_flush_discard", int'(count), 0);
    cyc(1'b1, 7, 6, 1'b1);
    cyc(1'b1, 5, 6, 1'b1);
    cyc(1'b1, 16'h000D, 6, 1'b1);
    idle(2, 6, 1'b1);
    chk("rc_num", got.size(), 2);
    if (got.size() == 2) begin
      chk("rc_out0", got[0], 5);
      chk("rc_out1", got[1], 5);
    end
    chk("rc_reject", int'(reject_cnt), 3);

    // N=1: everything maps to 0, nothing rejected.
    idle(2, 1, 1'b1);
    got.delete();
    repeat (20) cyc(1'b1, $urandom, 1, 1'b1);
    idle(2, 1, 1'b1);
    chk("n1_num", got.size(), 20);
    acc = 0;
    foreach (got[i]) acc |= got[i];
    chk("n1_all_zero", acc, 0);
    chk("n1_reject", int'(reject_cnt), 3);

    // Randomized traffic with occasional range changes and a mid-run reset.
    cur_n = 10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) cur_n = rtab[$urandom_range(8)];
      cyc($urandom_range(3) != 0, $urandom, cur_n, $urandom_range(1) != 0);
      if (i == 1500) begin
        rst = 1'b0;
        idle(2, cur_n, 1'b0);
        rst = 1'b1;
      end
    end

    // Reject counter saturation.
    rst = 1'b0;
    idle(1, 9, 1'b1);
    cyc(1'b1, 16'h000F, 9, 1'b1);
    rst = 1'b1;
    repeat (70000) cyc(1'b1, 16'h000F, 9, 1'b1);
    idle(1, 9, 1'b1);
    chk("reject_sat", int'(reject_cnt), 16'hFFFF);
    chk("sat_count", int'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
